// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver/host logic and the receive FIFO.
// rtsN exists only when UART_RX_FIFO_RTS_EN is defined.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              rxDone;
    logic [7:0]        rxOut;
    logic              outReady;
    logic              clrOvr;
    logic              flush;
    logic              outValid;
    logic [7:0]        outData;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              overrun;
`ifdef UART_RX_FIFO_RTS_EN
    logic              rtsN;

    modport master (
        output rxDone, rxOut, outReady, clrOvr, flush,
        input  outValid, outData, level, full, overrun, rtsN
    );
    modport slave (
        input  rxDone, rxOut, outReady, clrOvr, flush,
        output outValid, outData, level, full, overrun, rtsN
    );
`else
    modport master (
        output rxDone, rxOut, outReady, clrOvr, flush,
        input  outValid, outData, level, full, overrun
    );
    modport slave (
        input  rxDone, rxOut, outReady, clrOvr, flush,
        output outValid, outData, level, full, overrun
    );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: show-ahead output, level, sticky overrun.
// Optional RTS hysteresis output enabled by defining UART_RX_FIFO_RTS_EN.
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int HIGH_MARK = 12,
    parameter int LOW_MARK  = 4
) (
    input  logic            clk,
    input  logic            rstN,
    uart_rx_fifo_if.slave   bus
);
    localparam int LVL_W = ADDR_W + 1;

    if (DEPTH != (1 << ADDR_W) || DEPTH < 2) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be 2**ADDR_W and at least 2");
    end
    if (LOW_MARK >= HIGH_MARK || HIGH_MARK > DEPTH) begin : g_bad_marks
        $error("uart_rx_fifo: need LOW_MARK < HIGH_MARK <= DEPTH");
    end

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic              rx_done_prev;
    logic              overrun;
    logic              out_valid;
    logic              full;
    logic              wr_stb;
    logic              pop;
    logic              push;
    logic              drop;

    assign out_valid = (level != '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign wr_stb    = bus.rxDone & ~rx_done_prev;
    assign pop       = out_valid & bus.outReady;
    assign push      = wr_stb & (~full | pop);
    assign drop      = wr_stb & full & ~pop;

    // Storage is never reset; only pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (rstN && push && !bus.flush) begin
            mem[wr_ptr] <= bus.rxOut;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            rx_done_prev <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rx_done_prev <= bus.rxDone;
            if (bus.flush) begin
                rd_ptr <= wr_ptr;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
                level <= level + LVL_W'(push) - LVL_W'(pop);
            end
            // A drop in the same cycle as clrOvr keeps the flag set.
            if (drop) begin
                overrun <= 1'b1;
            end else if (bus.clrOvr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_RTS_EN
    logic rts_n;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            rts_n <= 1'b0;
        end else if (level >= LVL_W'(HIGH_MARK)) begin
            rts_n <= 1'b1;
        end else if (level <= LVL_W'(LOW_MARK)) begin
            rts_n <= 1'b0;
        end
    end

    assign bus.rtsN = rts_n;
`endif

    assign bus.outValid = out_valid;
    assign bus.outData  = mem[rd_ptr];
    assign bus.level    = level;
    assign bus.full     = full;
    assign bus.overrun  = overrun;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each completed byte on the receiver's done strobe (rxDone, rxOut) and stores it in a circular FIFO. Bytes are presented to the host logic through a show-ahead valid/ready interface. The block also reports fill level and overrun, and optionally drives RTS flow control.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, at least 2.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).
- HIGH_MARK, 12, level at or above which RTS deasserts (used only with the optional feature).
- LOW_MARK, 4, level at or below which RTS reasserts; must be less than HIGH_MARK (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rstN  input  1  synchronous active-low reset.
- rxDone  input  1  byte-complete strobe from the receiver; may stay high for more than one cycle.
- rxOut  input  8  received byte; valid while rxDone is high.
- outReady  input  1  consumer accepts the head byte this cycle.
- clrOvr  input  1  clears the sticky overrun flag.
- flush  input  1  discards all stored bytes.
- outValid  output  1  FIFO is not empty; outData is valid.
- outData  output  8  head byte (show-ahead).
- level  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
- full  output  1  level equals DEPTH.
- overrun  output  1  sticky flag: a byte was dropped.
- rtsN  output  1  only with UART_RX_FIFO_RTS_EN; 0 means the sender may transmit.

Behaviour:
- Reset: when rstN is 0 at a clock edge:
  - wrPtr, rdPtr, level and rxDonePrev clear to 0.
  - outValid=0, full=0, overrun=0, rtsN=0.
  - outData reads mem[0], whose contents are undefined.
  - Reset mid-operation discards stored bytes; memory contents are not cleared.
- Write strobe: wrStb = rxDone & ~rxDonePrev (rising-edge detect); rxDonePrev registers rxDone every cycle.
  - One byte is captured per rxDone pulse, however long the pulse lasts.
  - The captured byte is rxOut in the cycle where wrStb is 1.
- Pop: pop = outValid & outReady. rdPtr advances by 1, wrapping modulo DEPTH.
- Push: push = wrStb & (~full | pop).
  - On push, mem[wrPtr] is written with rxOut and wrPtr advances, wrapping modulo DEPTH.
  - When full, a push is accepted only if a pop occurs in the same cycle; level is then unchanged.
- Drop: wrStb & full & ~pop drops the byte.
  - The FIFO is unchanged and overrun is set to 1 on the next edge.
  - overrun stays high until clrOvr=1; if a drop and clrOvr occur in the same cycle, set wins.
- Level update:
  - level += push - pop, computed in ADDR_W+1 bits.
  - Never exceeds DEPTH and never underflows.
- Empty with wrStb and outReady both high: no pop (outValid=0). The push is accepted and level becomes 1.
- Latency: a byte pushed at edge N gives outValid=1 and outData equal to that byte after edge N. The host can pop it in cycle N+1.
- Outputs:
  - outData = mem[rdPtr], combinational from the memory read.
  - outValid = (level != 0), registered-derived.
  - full = (level == DEPTH).
- Flush: flush=1 sets rdPtr=wrPtr and level=0 on the next edge.
  - Any push or pop in that cycle is ignored.
  - overrun is unaffected.
  - Reset has priority over flush.
- Pointer wrap: pointers are ADDR_W bits and wrap naturally. Full and empty are distinguished only by level.

Optional Feature:
Macro UART_RX_FIFO_RTS_EN.
- Defined: adds the rtsN output with hysteresis, registered.
  - rtsN goes to 1 on the edge after level reaches HIGH_MARK or more.
  - rtsN returns to 0 on the edge after level reaches LOW_MARK or less.
  - Between the marks rtsN holds its value. Reset value is 0.
- Not defined: the rtsN port and its register do not exist; all other behaviour is identical.

Test Plan:
- Single byte: rxDone pulses 1 cycle with rxOut=0xA5, outReady=0. Next cycle outValid=1, outData=0xA5, level=1. Raising outReady for one cycle gives level=0, outValid=0.
- Long strobe: rxDone held high 5 cycles with rxOut=0x3C. Exactly one byte is stored, level=1.
- Fill and overrun: push 0x00..0x0F (16 bytes), then push 0x55 with outReady=0. Result: full=1, level=16, overrun=1. Draining yields 0x00..0x0F in order with no 0x55. After clrOvr=1, overrun=0.
- Full with simultaneous push/pop: FIFO full, wrStb with 0x77 and outReady=1 in the same cycle. level stays 16, overrun stays 0, and 0x77 is the last byte drained.
- Wrap and flush: push 10, pop 10, then push 10 bytes 0x80..0x89 (wraps the pointers). Data drains in order. Separately, flush=1 with level=6 gives level=0, outValid=0 next cycle.
- RTS (macro defined): push 12 bytes gives rtsN=1 one cycle after level=12. Pop down to 5 keeps rtsN=1. Pop to 4 gives rtsN=0 next cycle. Reset mid-fill gives level=0, rtsN=0.
